wb_resp_pipe: RTL and testbench
===============================

// Module: wb_resp_pipe
// PURPOSE
//  Parametrised Wishbone response-retiming stage between the memory side (controller / testbench
//  memories) and one or more core master ports (instruction + optional data memory).
//  Delays ack/dat by a configurable number of register stages per channel and squashes stale
//  responses when a cycle is abandoned. Optionally flags hung bus cycles with a timeout error.
//  Generalises the single-stage, fixed-width ack/data register used in the processor wrappers.
// PARAMETERS
//  DATA_WIDTH      32   width of each channel's read-data bus
//  NUM_CH          2    number of independent Wishbone channels (1..4)
//  LATENCY         1    response register stages per channel (0..8; 0 = combinational pass)
//  TIMEOUT_CYCLES  255  cycles of cyc&stb without a delivered ack before err (WB_TIMEOUT_EN only)
// PORTS
//  sys_clk   in   1                  system clock, all logic on rising edge
//  rst_n     in   1                  asynchronous active-low reset
//  cyc_i     in   NUM_CH             per-channel master cyc (sampled from the core)
//  stb_i     in   NUM_CH             per-channel master stb
//  ack_i     in   NUM_CH             per-channel slave ack (from memory side)
//  dat_i     in   NUM_CH*DATA_WIDTH  per-channel slave read data, ch k at [k*DATA_WIDTH +: DATA_WIDTH]
//  ack_o     out  NUM_CH             retimed ack to the core
//  dat_o     out  NUM_CH*DATA_WIDTH  retimed read data to the core
//  err_o     out  NUM_CH             timeout error pulse to the core (0 if WB_TIMEOUT_EN undefined)
//  busy_o    out  NUM_CH             1 while any pipe stage of the channel holds a valid response
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valid bits, ack_o, dat_o, err_o, busy_o, counters -> 0.
//    Reset mid-operation discards every in-flight response; no ack_o after release until new ack_i.
//  - Per channel: shift pipe of LATENCY stages, each {valid, data}. Stage0 loads valid=ack_i,
//    data=dat_i; stage n loads stage n-1. ack_o = last.valid, dat_o = last.data.
//  - Latency: ack_i at edge t appears on ack_o after edge t+LATENCY-1, i.e. visible cycle t+LATENCY.
//    LATENCY=0: ack_o=ack_i & cyc_i, dat_o=dat_i, no registers, busy_o=0.
//  - Throughput: fully pipelined, one ack per cycle per channel; back-to-back acks preserved in order.
//  - Data register of a stage loads only when its incoming valid=1; otherwise holds (dat_o keeps
//    last delivered word between acks).
//  - Flush: cyc_i[k]=0 in a cycle clears all valid bits of channel k on the next edge (data held);
//    ack_o[k] is also gated combinationally by cyc_i[k], so no ack lands outside a cycle.
//    ack_i concurrent with cyc_i=0 is dropped.
//  - Channels fully independent; no cross-channel ordering or arbitration.
//  - busy_o[k] = OR of channel k stage valid bits.
// CONFIGURATION
//  - WB_TIMEOUT_EN defined: per-channel counter, width clog2(TIMEOUT_CYCLES+1).
//    Counter increments each cycle cyc_i&stb_i=1 and ack_o=0; clears on ack_o=1 or cyc_i=0.
//    Counter == TIMEOUT_CYCLES-1 while incrementing -> err_o one-cycle pulse next cycle, counter
//    clears, pipe of that channel flushed. ack_o=1 in the same cycle the threshold would be hit ->
//    ack wins, no err_o, counter clears. err_o and ack_o never both 1.
//  - WB_TIMEOUT_EN undefined: no counters synthesised, err_o tied 0, TIMEOUT_CYCLES ignored.
// TESTING
//  1 LATENCY=2: ch0 cyc/stb=1, ack_i pulse at cycle 10 with dat_i=0xDEADBEEF -> ack_o[0]=1 only
//    in cycle 12, dat_o ch0=0xDEADBEEF from cycle 12 onward, ch1 outputs stay 0.
//  2 LATENCY=3: acks in cycles 5,6,7 with data 0x1,0x2,0x3 -> ack_o in 8,9,10 with 0x1,0x2,0x3.
//  3 Flush: LATENCY=3, ack_i at cycle 5, cyc_i drops cycle 6 -> no ack_o in cycles 6..12, busy_o=0
//    from cycle 7.
//  4 WB_TIMEOUT_EN, TIMEOUT_CYCLES=16: cyc/stb held from cycle 0, no ack -> err_o=1 only in
//    cycle 16; repeats at cycle 32 if still held; ack_o delivered at cycle 15 -> no err_o.
//  5 Async reset: rst_n low mid-cycle with 2 responses in flight -> all outputs 0 immediately,
//    no ack_o after release until a new ack_i.
//  6 LATENCY=0, NUM_CH=2: simultaneous ack_i=2'b11, dat_i={0xA5A5A5A5,0x5A5A5A5A} -> same-cycle
//    ack_o=2'b11 with matching data; ack_i with cyc_i=0 -> ack_o=0.

Source files
------------

// File: rtl/wb_resp_pipe.sv
// Wishbone response retiming stage: per-channel ack/data shift pipe with flush on abandoned cycles.
// Optional hung-cycle timeout with an err_o pulse is enabled by defining WB_TIMEOUT_EN.
module wb_resp_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CH         = 2,
  parameter int LATENCY        = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         sys_clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            cyc_i,
  input  logic [NUM_CH-1:0]            stb_i,
  input  logic [NUM_CH-1:0]            ack_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] dat_i,
  output logic [NUM_CH-1:0]            ack_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] dat_o,
  output logic [NUM_CH-1:0]            err_o,
  output logic [NUM_CH-1:0]            busy_o
);

  logic [NUM_CH-1:0] w_tmo_hit;
  logic [NUM_CH-1:0] w_err;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic w_ack_raw;

    if (LATENCY == 0) begin : g_comb
      assign w_ack_raw                       = ack_i[k];
      assign dat_o[k*DATA_WIDTH +: DATA_WIDTH] = dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign busy_o[k]                       = 1'b0;
    end else begin : g_pipe
      logic                  w_flush;
      logic [LATENCY-1:0]    r_vld;
      logic [DATA_WIDTH-1:0] r_dat [LATENCY];

      // Abandoned or timed-out cycle: drop every in-flight response, keep the data words.
      assign w_flush = ~cyc_i[k] | w_tmo_hit[k];

      always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= '0;
          for (int s = 0; s < LATENCY; s++) r_dat[s] <= '0;
        end else begin
          if (w_flush) begin
            r_vld <= '0;
          end else begin
            r_vld[0] <= ack_i[k];
            for (int s = 1; s < LATENCY; s++) r_vld[s] <= r_vld[s-1];
          end
          if (!w_flush && ack_i[k]) r_dat[0] <= dat_i[k*DATA_WIDTH +: DATA_WIDTH];
          for (int s = 1; s < LATENCY; s++) begin
            if (!w_flush && r_vld[s-1]) r_dat[s] <= r_dat[s-1];
          end
        end
      end

      assign w_ack_raw                         = r_vld[LATENCY-1];
      assign dat_o[k*DATA_WIDTH +: DATA_WIDTH] = r_dat[LATENCY-1];
      assign busy_o[k]                         = |r_vld;
    end

    // An err pulse suppresses a same-cycle ack so the two are never seen together.
    assign ack_o[k] = w_ack_raw & cyc_i[k] & ~w_err[k];
  end

  assign err_o = w_err;

`ifdef WB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_tmo
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;
    logic             w_inc;

    assign w_inc        = cyc_i[k] & stb_i[k] & ~ack_o[k];
    assign w_tmo_hit[k] = w_inc & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        r_err <= w_tmo_hit[k];
        if (ack_o[k] || !cyc_i[k] || w_tmo_hit[k]) r_cnt <= '0;
        else if (w_inc)                             r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_err[k] = r_err;
  end
`else
  logic w_unused;

  assign w_tmo_hit = '0;
  assign w_err     = '0;
  assign w_unused  = ^{stb_i, 1'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_wb_resp_pipe.sv
// Directed bench for wb_resp_pipe: three instances (LATENCY 0/2/3) share one stimulus stream.
// Timeout expectations follow whether WB_TIMEOUT_EN is defined for the build.
module tb_wb_resp_pipe;

  localparam int DW  = 32;
  localparam int NCH = 2;
  localparam int TMO = 16;
`ifdef WB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic            sys_clk = 1'b0;
  logic            rst_n   = 1'b0;
  logic [NCH-1:0]  cyc_i   = '0;
  logic [NCH-1:0]  stb_i   = '0;
  logic [NCH-1:0]  ack_i   = '0;
  logic [NCH*DW-1:0] dat_i = '0;

  logic [NCH-1:0] l0_ack, l0_err, l0_busy;
  logic [NCH-1:0] l2_ack, l2_err, l2_busy;
  logic [NCH-1:0] l3_ack, l3_err, l3_busy;
  logic [NCH*DW-1:0] l0_dat, l2_dat, l3_dat;

  wb_resp_pipe #(.DATA_WIDTH(DW), .NUM_CH(NCH), .LATENCY(0), .TIMEOUT_CYCLES(TMO)) u_l0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .ack_i(ack_i), .dat_i(dat_i),
    .ack_o(l0_ack), .dat_o(l0_dat), .err_o(l0_err), .busy_o(l0_busy));

  wb_resp_pipe #(.DATA_WIDTH(DW), .NUM_CH(NCH), .LATENCY(2), .TIMEOUT_CYCLES(TMO)) u_l2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .ack_i(ack_i), .dat_i(dat_i),
    .ack_o(l2_ack), .dat_o(l2_dat), .err_o(l2_err), .busy_o(l2_busy));

  wb_resp_pipe #(.DATA_WIDTH(DW), .NUM_CH(NCH), .LATENCY(3), .TIMEOUT_CYCLES(TMO)) u_l3 (
    .sys_clk(sys_clk), .rst_n(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .ack_i(ack_i), .dat_i(dat_i),
    .ack_o(l3_ack), .dat_o(l3_dat), .err_o(l3_err), .busy_o(l3_busy));

  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  cyc;
    logic [1:0]  ack;
    logic [63:0] dat;
    logic [1:0]  exp_ack;
    logic [63:0] exp_dat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] c, input logic [1:0] a, input logic [63:0] d);
    cyc_i = c;
    stb_i = c;
    ack_i = a;
    dat_i = d;
  endtask

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(2'b00, 2'b00, 64'h0);
    repeat (n) next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b11, 2'b11, 64'hA5A5A5A5_5A5A5A5A, 2'b11, 64'hA5A5A5A5_5A5A5A5A};
    vecs[1] = '{2'b01, 2'b11, 64'h00000001_00000002, 2'b01, 64'h00000001_00000002};
    vecs[2] = '{2'b00, 2'b11, 64'h00000003_00000004, 2'b00, 64'h00000003_00000004};
    vecs[3] = '{2'b10, 2'b01, 64'h00000005_00000006, 2'b00, 64'h00000005_00000006};
    vecs[4] = '{2'b11, 2'b10, 64'h12345678_00000000, 2'b10, 64'h12345678_00000000};
    vecs[5] = '{2'b10, 2'b10, 64'hFFFFFFFF_0000FFFF, 2'b10, 64'hFFFFFFFF_0000FFFF};

    // reset state
    drive(2'b00, 2'b00, 64'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_l2_ctl", 0, {l2_ack, l2_err, l2_busy}, 64'h0);
    chk("rst_l2_dat", 0, l2_dat, 64'h0);
    chk("rst_l3_ctl", 0, {l3_ack, l3_err, l3_busy}, 64'h0);
    chk("rst_l3_dat", 0, l3_dat, 64'h0);
    chk("rst_l0_ctl", 0, {l0_ack, l0_err, l0_busy}, 64'h0);
    rst_n = 1'b1;
    next_cycle();

    // single ack through LATENCY=2; ch1 untouched
    for (int r = 0; r < 15; r++) begin
      drive(2'b01, (r == 10) ? 2'b01 : 2'b00, (r == 10) ? 64'h00000000_DEADBEEF : 64'h0);
      @(negedge sys_clk);
      chk("t1_l2_ack", r, l2_ack, (r == 12) ? 2'b01 : 2'b00);
      chk("t1_l2_dat0", r, l2_dat[31:0], (r >= 12) ? 32'hDEADBEEF : 32'h0);
      chk("t1_l2_ch1", r, {l2_ack[1], l2_busy[1], l2_err[1], l2_dat[63:32]}, 64'h0);
      chk("t1_l3_ack", r, l3_ack, (r == 13) ? 2'b01 : 2'b00);
      chk("t1_l0_ack", r, l0_ack, (r == 10) ? 2'b01 : 2'b00);
      next_cycle();
    end
    idle(3);

    // back-to-back acks through LATENCY=3 (and 2)
    for (int r = 0; r < 13; r++) begin
      drive(2'b01, (r >= 5 && r <= 7) ? 2'b01 : 2'b00, (r >= 5 && r <= 7) ? 64'(r - 4) : 64'h0);
      @(negedge sys_clk);
      chk("t2_l3_ack", r, l3_ack, (r >= 8 && r <= 10) ? 2'b01 : 2'b00);
      chk("t2_l3_dat0", r, l3_dat[31:0],
          (r < 8) ? 32'hDEADBEEF : (r == 8) ? 32'h1 : (r == 9) ? 32'h2 : 32'h3);
      chk("t2_l2_ack", r, l2_ack, (r >= 7 && r <= 9) ? 2'b01 : 2'b00);
      chk("t2_l2_dat0", r, l2_dat[31:0],
          (r < 7) ? 32'hDEADBEEF : (r == 7) ? 32'h1 : (r == 8) ? 32'h2 : 32'h3);
      next_cycle();
    end
    idle(3);

    // flush: cyc drops right after an ack; ack with cyc=0 is dropped
    for (int r = 0; r < 13; r++) begin
      drive((r <= 5 || r >= 10) ? 2'b01 : 2'b00,
            (r == 5 || r == 8) ? 2'b01 : 2'b00,
            (r == 5) ? 64'h77 : (r == 8) ? 64'h88 : 64'h0);
      @(negedge sys_clk);
      chk("t3_l3_ack", r, l3_ack, 2'b00);
      chk("t3_l2_ack", r, l2_ack, 2'b00);
      chk("t3_l3_busy", r, l3_busy, (r == 6) ? 2'b01 : 2'b00);
      chk("t3_l2_busy", r, l2_busy, (r == 6) ? 2'b01 : 2'b00);
      chk("t3_l3_dat0", r, l3_dat[31:0], 32'h3);
      chk("t3_l2_dat0", r, l2_dat[31:0], 32'h3);
      chk("t3_l0_ack", r, l0_ack, (r == 5) ? 2'b01 : 2'b00);
      next_cycle();
    end
    idle(3);

    // hung cycle: err pulses at 16 and 32 when the timeout is built in
    for (int r = 0; r < 41; r++) begin
      drive(2'b01, 2'b00, 64'h0);
      @(negedge sys_clk);
      chk("t4a_l0_err", r, l0_err, (TMO_ON && (r == 16 || r == 32)) ? 2'b01 : 2'b00);
      chk("t4a_l2_err", r, l2_err, (TMO_ON && (r == 16 || r == 32)) ? 2'b01 : 2'b00);
      chk("t4a_l3_err", r, l3_err, (TMO_ON && (r == 16 || r == 32)) ? 2'b01 : 2'b00);
      next_cycle();
    end
    idle(2);

    // ack_o at the threshold cycle wins on LATENCY=0; late pipes time out and squash the ack
    for (int r = 0; r < 21; r++) begin
      drive(2'b01, (r == 15) ? 2'b01 : 2'b00, (r == 15) ? 64'h00000000_CAFEF00D : 64'h0);
      @(negedge sys_clk);
      chk("t4b_l0_err", r, l0_err, 2'b00);
      chk("t4b_l0_ack", r, l0_ack, (r == 15) ? 2'b01 : 2'b00);
      chk("t4b_l2_err", r, l2_err, (TMO_ON && r == 16) ? 2'b01 : 2'b00);
      chk("t4b_l2_ack", r, l2_ack, (!TMO_ON && r == 17) ? 2'b01 : 2'b00);
      chk("t4b_l3_err", r, l3_err, (TMO_ON && r == 16) ? 2'b01 : 2'b00);
      chk("t4b_l3_ack", r, l3_ack, (!TMO_ON && r == 18) ? 2'b01 : 2'b00);
      next_cycle();
    end
    idle(2);

    // async reset with two responses in flight
    for (int r = 0; r < 14; r++) begin
      drive(2'b01, (r == 2 || r == 3 || r == 10) ? 2'b01 : 2'b00,
            (r == 2) ? 64'h11 : (r == 3) ? 64'h22 : (r == 10) ? 64'h99 : 64'h0);
      @(negedge sys_clk);
      if (r == 4) begin
        chk("t5_l2_ack_pre", r, l2_ack, 2'b01);
        chk("t5_l2_dat_pre", r, l2_dat[31:0], 32'h11);
        chk("t5_l3_busy_pre", r, l3_busy, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_l2_rst_ctl", r, {l2_ack, l2_err, l2_busy}, 64'h0);
        chk("t5_l2_rst_dat", r, l2_dat, 64'h0);
        chk("t5_l3_rst_ctl", r, {l3_ack, l3_err, l3_busy}, 64'h0);
        chk("t5_l3_rst_dat", r, l3_dat, 64'h0);
      end
      if (r >= 5) begin
        chk("t5_l2_ack", r, l2_ack, (r == 12) ? 2'b01 : 2'b00);
        chk("t5_l2_dat0", r, l2_dat[31:0], (r >= 12) ? 32'h99 : 32'h0);
        chk("t5_l3_ack", r, l3_ack, (r == 13) ? 2'b01 : 2'b00);
        chk("t5_l3_dat0", r, l3_dat[31:0], (r >= 13) ? 32'h99 : 32'h0);
      end
      if (r == 6) #2 rst_n = 1'b1;
      next_cycle();
    end
    idle(2);

    // LATENCY=0 combinational vectors
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].cyc, vecs[i].ack, vecs[i].dat);
      @(negedge sys_clk);
      chk("t6_l0_ack", i, l0_ack, vecs[i].exp_ack);
      chk("t6_l0_dat", i, l0_dat, vecs[i].exp_dat);
      chk("t6_l0_busy", i, l0_busy, 2'b00);
      next_cycle();
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
